// File: rtl/morse_keyer.sv
// morse_keyer: ASCII-in, International Morse key_out with unit prescaler.
// Optional MORSE_PUNCT_EN adds '.', ',' and '?' (6-element codes).
module morse_keyer #(
  parameter int UNIT_CYCLES = 2700000,
  parameter int CNT_W       = 22
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       key_out,
  output logic       busy,
  output logic       err_pulse
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_MARK     = 3'd1;
  localparam logic [2:0] S_ELEM_GAP = 3'd2;
  localparam logic [2:0] S_CHAR_GAP = 3'd3;
  localparam logic [2:0] S_WORD_GAP = 3'd4;

  localparam logic [CNT_W-1:0] UNIT_LAST = CNT_W'(UNIT_CYCLES - 1);

  logic [2:0]       state_q;
  logic [CNT_W-1:0] presc_q;
  logic [1:0]       unit_q;
  logic [5:0]       pat_q;
  logic [2:0]       rem_q;
  logic             key_q;
  logic             err_q;

  logic       accept;
  logic       is_space;
  logic       is_sym;
  logic       tick;
  logic [8:0] code;

  // {len[2:0], pattern[5:0]}, pattern left-aligned, 1 = dash
  function automatic logic [8:0] lookup(input logic [7:0] c);
    logic [7:0] u;
    logic [8:0] r;
    u = (c >= 8'h61 && c <= 8'h7a) ? c - 8'h20 : c;
    r = 9'd0;
    case (u)
      8'h41: r = {3'd2, 6'b010000};
      8'h42: r = {3'd4, 6'b100000};
      8'h43: r = {3'd4, 6'b101000};
      8'h44: r = {3'd3, 6'b100000};
      8'h45: r = {3'd1, 6'b000000};
      8'h46: r = {3'd4, 6'b001000};
      8'h47: r = {3'd3, 6'b110000};
      8'h48: r = {3'd4, 6'b000000};
      8'h49: r = {3'd2, 6'b000000};
      8'h4a: r = {3'd4, 6'b011100};
      8'h4b: r = {3'd3, 6'b101000};
      8'h4c: r = {3'd4, 6'b010000};
      8'h4d: r = {3'd2, 6'b110000};
      8'h4e: r = {3'd2, 6'b100000};
      8'h4f: r = {3'd3, 6'b111000};
      8'h50: r = {3'd4, 6'b011000};
      8'h51: r = {3'd4, 6'b110100};
      8'h52: r = {3'd3, 6'b010000};
      8'h53: r = {3'd3, 6'b000000};
      8'h54: r = {3'd1, 6'b100000};
      8'h55: r = {3'd3, 6'b001000};
      8'h56: r = {3'd4, 6'b000100};
      8'h57: r = {3'd3, 6'b011000};
      8'h58: r = {3'd4, 6'b100100};
      8'h59: r = {3'd4, 6'b101100};
      8'h5a: r = {3'd4, 6'b110000};
      8'h30: r = {3'd5, 6'b111110};
      8'h31: r = {3'd5, 6'b011110};
      8'h32: r = {3'd5, 6'b001110};
      8'h33: r = {3'd5, 6'b000110};
      8'h34: r = {3'd5, 6'b000010};
      8'h35: r = {3'd5, 6'b000000};
      8'h36: r = {3'd5, 6'b100000};
      8'h37: r = {3'd5, 6'b110000};
      8'h38: r = {3'd5, 6'b111000};
      8'h39: r = {3'd5, 6'b111100};
`ifdef MORSE_PUNCT_EN
      8'h2e: r = {3'd6, 6'b010101};
      8'h2c: r = {3'd6, 6'b110011};
      8'h3f: r = {3'd6, 6'b001100};
`else
`endif
      default: r = 9'd0;
    endcase
    return r;
  endfunction

  // handshake and character classification
  always_comb begin
    char_ready = (state_q == S_IDLE) & rst_n;
    accept     = char_valid & char_ready;
    code       = lookup(char_in);
    is_space   = (char_in == 8'h20);
    is_sym     = (code[8:6] != 3'd0);
    tick       = (presc_q == UNIT_LAST);
  end

  assign key_out   = key_q;
  assign err_pulse = err_q;
  assign busy      = (state_q != S_IDLE);

  // keying FSM with unit prescaler and per-segment unit countdown
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      unit_q  <= '0;
      pat_q   <= '0;
      rem_q   <= '0;
      key_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (state_q == S_IDLE) begin
        presc_q <= '0;
        if (accept) begin
          if (is_space) begin
            state_q <= S_WORD_GAP;
            unit_q  <= 2'd3;
          end else if (is_sym) begin
            state_q <= S_MARK;
            key_q   <= 1'b1;
            unit_q  <= code[5] ? 2'd2 : 2'd0;
            pat_q   <= {code[4:0], 1'b0};
            rem_q   <= code[8:6] - 3'd1;
          end else begin
            err_q <= 1'b1;
          end
        end
      end else if (!tick) begin
        presc_q <= presc_q + 1'b1;
      end else begin
        presc_q <= '0;
        if (unit_q != 2'd0) begin
          unit_q <= unit_q - 2'd1;
        end else begin
          unique case (1'b1)
            (state_q == S_MARK): begin
              key_q <= 1'b0;
              if (rem_q != 3'd0) begin
                state_q <= S_ELEM_GAP;
                unit_q  <= 2'd0;
              end else begin
                state_q <= S_CHAR_GAP;
                unit_q  <= 2'd2;
              end
            end
            (state_q == S_ELEM_GAP): begin
              state_q <= S_MARK;
              key_q   <= 1'b1;
              unit_q  <= pat_q[5] ? 2'd2 : 2'd0;
              pat_q   <= {pat_q[4:0], 1'b0};
              rem_q   <= rem_q - 3'd1;
            end
            default: begin
              state_q <= S_IDLE;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: doc/morse_keyer.md
Name: morse_keyer

Overview:
- Transmit-side counterpart to the single-button texter input path: accepts ASCII characters over a valid/ready handshake and produces a timed on/off keying signal (International Morse) for the board LED/buzzer.
- Runs on the 27 MHz system clock.
- Timing is derived from one prescaled "unit" (dot length).
- Sits between the character source (UART/ROM message sequencer) and the output pin driver.

Parameters:
- UNIT_CYCLES, 2700000, clock cycles per Morse unit (100 ms at 27 MHz); legal range 2 to 2^22-1.
- CNT_W, 22, width of the unit prescaler counter; must satisfy 2^CNT_W > UNIT_CYCLES.

Ports:
- clk  input  1  system clock (27 MHz), all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- char_in  input  8  ASCII character to send.
- char_valid  input  1  char_in valid; held until accepted.
- char_ready  output  1  keyer can accept a character this cycle.
- key_out  output  1  registered keying output; 1 = tone/LED on.
- busy  output  1  high whenever FSM is not IDLE.
- err_pulse  output  1  one-cycle pulse when an unsupported character is accepted.

Behaviour:
- Reset (rst_n low at a rising edge):
  - State goes to IDLE; key_out=0, err_pulse=0, busy=0; prescaler and symbol counters cleared.
  - char_ready=0 while rst_n is low (combinational gate).
- Reset mid-character aborts immediately: key_out=0 on the reset edge, nothing resumes.
- Handshake:
  - char_ready = (state==IDLE) & rst_n.
  - A character is accepted on the edge where char_valid & char_ready; char_in is sampled only then.
  - The cycle after acceptance, char_ready=0.
  - Holding char_valid across characters is legal; the next character is accepted on the first IDLE cycle.
- Lookup (combinational table): 3-bit length plus 6-bit pattern, MSB-first, 1=dash.
  - Supported: 'A'-'Z', 'a'-'z' (same codes as uppercase), '0'-'9', space (0x20).
- Timing, with one unit = UNIT_CYCLES clocks:
  - dot mark 1 unit; dash mark 3 units.
  - intra-character gap 1 unit; inter-character gap 3 units after the last element.
  - space: 4 units off, giving 7 total after a preceding character's 3-unit gap.
- States: IDLE, MARK, ELEM_GAP, CHAR_GAP, WORD_GAP.
  - IDLE, on accept of a letter/digit -> MARK; key_out=1 from the accept edge, so it is visible the cycle after the handshake.
  - IDLE, on accept of space -> WORD_GAP.
  - IDLE, on accept of an unsupported character -> stay IDLE; err_pulse=1 for exactly the next cycle; char_ready=1 again that same cycle.
  - MARK, element done -> ELEM_GAP if elements remain, else CHAR_GAP; key_out=0 on that edge.
  - ELEM_GAP, done -> MARK with the next element; key_out=1.
  - CHAR_GAP or WORD_GAP, done -> IDLE.
- Every mark and gap lasts exactly N*UNIT_CYCLES cycles. Prescaler wraps at UNIT_CYCLES-1; the unit counter counts down from N-1.
- Total occupancy for a character = (sum of element units + gaps) * UNIT_CYCLES. Example: 'E' = 4 units, so char_ready returns exactly 4*UNIT_CYCLES cycles after acceptance.
- key_out is glitch-free: it changes only at element boundaries and reset.

Optional Feature:
- MORSE_PUNCT_EN:
  - Defined: adds '.' (.-.-.-), ',' (--..--), '?' (..--..) to the table; these use the full 6-element length.
  - Undefined: these three characters are unsupported (err_pulse, no keying), and the table never produces more than 5 elements.

Test Plan:
- UNIT_CYCLES=4: send 'E' -> key_out high 4 cycles then low 12; char_ready high again 16 cycles after accept; err_pulse never asserted.
- Send 'A' -> key_out high 4, low 4, high 12, low 12; busy high for exactly 32 cycles.
- Send 'e' then ' ' back-to-back with char_valid held -> 'e' identical to 'E'; space accepted on the first ready cycle, key_out low 16 cycles; total idle between 'e' mark and next ready is 28 cycles.
- Send '#' (0x23) -> err_pulse high exactly 1 cycle, key_out stays 0, char_ready high the cycle after accept.
- Send 'T', assert rst_n low on cycle 5 of the dash -> key_out=0 after that edge, char_ready=0 while reset is held, IDLE with ready=1 after release; the next 'E' is timed normally.
- With MORSE_PUNCT_EN, send '?' -> pattern dot,dot,dash,dash,dot,dot (4,4,4,4,12,4,12,4,4,4,4 cycles alternating on/off) then 12 off; without the macro -> err_pulse.
